// File: rtl/fde_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fde_pipeline_ctrl
// Purpose  : Fetch/decode/execute pipeline sequencer. Holds the pipe frozen
//            after reset, stalls on load-use hazards and on instruction fetch
//            misses, and flushes on taken branches. A saturating counter
//            tracks bubble cycles.
// Revision : 1.0  initial release
// ============================================================================
module fde_pipeline_ctrl #(
  parameter int REG_ADDR_W     = 5,
  parameter int STARTUP_CYCLES = 4,
  parameter int FLUSH_CYCLES   = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  imem_ready_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_is_load_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_branch_taken_i,
  output logic                  pc_en_o,
  output logic                  if_id_en_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_en_o,
  output logic                  id_ex_bubble_o,
  output logic [1:0]            state_o,
  output logic [15:0]           bubble_count_o
);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_UNUSED  = 2'd3
  } state_e;

  localparam int SCNT_W = $clog2(STARTUP_CYCLES + 1);
  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STARTUP_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLUSH_CYCLES - 1);

  state_e              state_q, state_d;
  logic [SCNT_W-1:0]   startup_cnt_q, startup_cnt_d;
  logic [FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [15:0]         bubble_q, bubble_d;

  logic                branch_w;
  logic                load_use_w;

  assign branch_w   = ex_valid_i & ex_branch_taken_i;
  // A load whose destination feeds the decode instruction must hold decode
  // one cycle; x0 is hard-wired zero so it never creates a dependency.
  assign load_use_w = ex_valid_i & ex_is_load_i & id_valid_i & (ex_rd_i != '0)
                    & ((id_uses_rs1_i & (id_rs1_i == ex_rd_i))
                     | (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));

  // Same-cycle control outputs and next-state selection.
  always_comb begin
    pc_en_o        = 1'b0;
    if_id_en_o     = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_en_o     = 1'b0;
    id_ex_bubble_o = 1'b0;
    state_d        = state_q;
    startup_cnt_d  = startup_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    case (state_q)
      ST_STARTUP: begin
        if (startup_cnt_q == SCNT_LAST) begin
          state_d       = ST_RUN;
          startup_cnt_d = '0;
        end else begin
          startup_cnt_d = startup_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (branch_w) begin
          pc_en_o        = 1'b1;
          if_id_en_o     = 1'b1;
          if_id_flush_o  = 1'b1;
          id_ex_en_o     = 1'b1;
          id_ex_bubble_o = 1'b1;
          state_d        = ST_FLUSH;
          flush_cnt_d    = '0;
        end else if (load_use_w) begin
          id_ex_en_o     = 1'b1;
          id_ex_bubble_o = 1'b1;
        end else if (!imem_ready_i) begin
          // Decode still issues; only the fetch slot is squashed.
          if_id_en_o     = 1'b1;
          if_id_flush_o  = 1'b1;
          id_ex_en_o     = 1'b1;
        end else begin
          pc_en_o        = 1'b1;
          if_id_en_o     = 1'b1;
          id_ex_en_o     = 1'b1;
        end
      end
      ST_FLUSH: begin
        pc_en_o        = imem_ready_i;
        if_id_en_o     = 1'b1;
        if_id_flush_o  = 1'b1;
        id_ex_en_o     = 1'b1;
        id_ex_bubble_o = 1'b1;
        if (flush_cnt_q == FCNT_LAST) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d       = ST_STARTUP;
        startup_cnt_d = '0;
        flush_cnt_d   = '0;
      end
    endcase
    bubble_d = (id_ex_bubble_o && (bubble_q != 16'hFFFF)) ? bubble_q + 16'd1 : bubble_q;
  end

  // State, phase counters and bubble counter.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= ST_STARTUP;
      startup_cnt_q <= '0;
      flush_cnt_q   <= '0;
      bubble_q      <= '0;
    end else begin
      state_q       <= state_d;
      startup_cnt_q <= startup_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      bubble_q      <= bubble_d;
    end
  end

  assign state_o        = state_q;
  assign bubble_count_o = bubble_q;

endmodule
`default_nettype wire

// File: tb/tb_fde_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fde_pipeline_ctrl
// Purpose  : Self-checking bench for fde_pipeline_ctrl: vector table, corner
//            sequences, randomized traffic against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fde_pipeline_ctrl;

  localparam int STARTUP_CYCLES = 4;
  localparam int FLUSH_CYCLES   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_ready, id_valid, id_uses_rs1, id_uses_rs2;
  logic       ex_valid, ex_is_load, ex_branch_taken;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
  logic [1:0] state;
  logic [15:0] bubble_count;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: phase plus cycles remaining in a timed phase.
  int          m_phase;   // 0 startup, 1 run, 2 flush
  int          m_left;
  logic [15:0] m_bub;

  fde_pipeline_ctrl #(
    .REG_ADDR_W(5), .STARTUP_CYCLES(STARTUP_CYCLES), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clock_i(clk), .reset_n_i(rst_n), .imem_ready_i(imem_ready),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
    .ex_valid_i(ex_valid), .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd),
    .ex_branch_taken_i(ex_branch_taken),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .if_id_flush_o(if_id_flush),
    .id_ex_en_o(id_ex_en), .id_ex_bubble_o(id_ex_bubble),
    .state_o(state), .bubble_count_o(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       imem, idv, u1, u2, exv, ld;
    logic [4:0] rs1, rs2, rd;
    logic [4:0] exp;   // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble}
  } vec_t;

  vec_t vecs [10];

  task automatic m_reset();
    m_phase = 0;
    m_left  = STARTUP_CYCLES;
    m_bub   = 16'd0;
  endtask

  function automatic logic [4:0] m_ctrl();
    logic lu;
    if (!rst_n || m_phase == 0) return 5'b00000;
    if (m_phase == 2) return {imem_ready, 4'b1111};
    if (ex_valid && ex_branch_taken) return 5'b11111;
    lu = ex_valid && ex_is_load && id_valid && (ex_rd != 5'd0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (lu) return 5'b00011;
    if (!imem_ready) return 5'b01110;
    return 5'b11010;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [4:0] dut_ctrl();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble};
  endfunction

  task automatic check_model(string name);
    check({name, ".ctrl"}, {27'd0, dut_ctrl()}, {27'd0, m_ctrl()});
    check({name, ".state"}, {30'd0, state}, m_phase[31:0]);
    check({name, ".bubbles"}, {16'd0, bubble_count}, {16'd0, m_bub});
  endtask

  // Advance one clock edge, updating the model with pre-edge inputs.
  task automatic tick();
    logic [4:0] c;
    c = m_ctrl();
    @(posedge clk);
    if (!rst_n) m_reset();
    else begin
      if (c[0] && m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
      case (m_phase)
        0: begin m_left--; if (m_left == 0) m_phase = 1; end
        1: if (ex_valid && ex_branch_taken) begin m_phase = 2; m_left = FLUSH_CYCLES; end
        default: begin m_left--; if (m_left == 0) m_phase = 1; end
      endcase
    end
    #1;
  endtask

  task automatic idle();
    imem_ready = 1'b1; id_valid = 1'b0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
  endtask

  task automatic set_load_use(logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd;
    id_valid = 1'b1; id_uses_rs1 = 1'b1; id_rs1 = rd;
  endtask

  task automatic restart();
    rst_n = 1'b0; idle(); m_reset();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < STARTUP_CYCLES; i++) tick();
  endtask

  initial begin
    logic [15:0] b0;
    vecs[0] = '{imem:1, idv:1, u1:1, u2:1, exv:1, ld:0, rs1:5, rs2:6, rd:5, exp:5'b11010};
    vecs[1] = '{imem:1, idv:1, u1:1, u2:0, exv:1, ld:1, rs1:5, rs2:6, rd:5, exp:5'b00011};
    vecs[2] = '{imem:1, idv:1, u1:1, u2:1, exv:1, ld:1, rs1:0, rs2:0, rd:0, exp:5'b11010};
    vecs[3] = '{imem:1, idv:1, u1:1, u2:1, exv:1, ld:1, rs1:3, rs2:7, rd:7, exp:5'b00011};
    vecs[4] = '{imem:1, idv:1, u1:1, u2:0, exv:1, ld:1, rs1:3, rs2:7, rd:7, exp:5'b11010};
    vecs[5] = '{imem:1, idv:0, u1:1, u2:1, exv:1, ld:1, rs1:9, rs2:9, rd:9, exp:5'b11010};
    vecs[6] = '{imem:1, idv:1, u1:1, u2:1, exv:0, ld:1, rs1:9, rs2:9, rd:9, exp:5'b11010};
    vecs[7] = '{imem:0, idv:1, u1:1, u2:1, exv:1, ld:0, rs1:9, rs2:9, rd:9, exp:5'b01110};
    vecs[8] = '{imem:0, idv:1, u1:0, u2:1, exv:1, ld:1, rs1:2, rs2:9, rd:9, exp:5'b00011};
    vecs[9] = '{imem:1, idv:1, u1:0, u2:1, exv:1, ld:1, rs1:9, rs2:2, rd:9, exp:5'b11010};

    // Reset held for three cycles, then the startup freeze.
    idle(); rst_n = 1'b0; m_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset.ctrl", {27'd0, dut_ctrl()}, 32'd0);
      check("reset.state", {30'd0, state}, 32'd0);
      tick();
    end
    rst_n = 1'b1;
    for (int i = 0; i < STARTUP_CYCLES; i++) begin
      #1; check("startup.ctrl", {27'd0, dut_ctrl()}, 32'd0);
      check("startup.state", {30'd0, state}, 32'd0);
      tick();
    end
    #1; check("run.state", {30'd0, state}, 32'd1);
    check("run.ctrl", {27'd0, dut_ctrl()}, 32'b11010);

    // Single-cycle decode scenarios in RUN.
    for (int i = 0; i < 10; i++) begin
      imem_ready = vecs[i].imem; id_valid = vecs[i].idv;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
      ex_valid = vecs[i].exv; ex_is_load = vecs[i].ld; ex_branch_taken = 1'b0;
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
      #1;
      check($sformatf("vec%0d.ctrl", i), {27'd0, dut_ctrl()}, {27'd0, vecs[i].exp});
      check($sformatf("vec%0d.state", i), {30'd0, state}, 32'd1);
      b0 = bubble_count;
      tick();
      check($sformatf("vec%0d.bubbles", i), {16'd0, bubble_count},
            {16'd0, b0 + {15'd0, vecs[i].exp[0]}});
    end

    // Taken branch: one detect cycle plus two flush cycles, all bubbles.
    idle(); ex_valid = 1'b1; ex_branch_taken = 1'b1; b0 = bubble_count;
    #1; check("br.ctrl", {27'd0, dut_ctrl()}, 32'b11111);
    tick();
    for (int i = 0; i < FLUSH_CYCLES; i++) begin
      set_load_use(5'd4); ex_branch_taken = 1'b1;   // ignored while flushing
      check("br.flush.state", {30'd0, state}, 32'd2);
      check("br.flush.ctrl", {27'd0, dut_ctrl()}, 32'b11111);
      tick();
    end
    idle();
    #1; check("br.back.state", {30'd0, state}, 32'd1);
    check("br.bubbles", {16'd0, bubble_count}, {16'd0, b0 + 16'd3});

    // Branch together with a matching load-use: branch wins.
    set_load_use(5'd6); ex_branch_taken = 1'b1; imem_ready = 1'b0;
    #1; check("br_lu.ctrl", {27'd0, dut_ctrl()}, 32'b11111);
    tick();
    check("br_lu.state", {30'd0, state}, 32'd2);
    idle(); imem_ready = 1'b0;
    #1; check("flush.imem0.ctrl", {27'd0, dut_ctrl()}, 32'b01111);
    tick(); idle(); tick();

    // Fetch miss for three cycles: decode still issues, no bubbles.
    b0 = bubble_count;
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b0; id_valid = 1'b1;
      #1; check("fw.ctrl", {27'd0, dut_ctrl()}, 32'b01110);
      tick();
    end
    check("fw.bubbles", {16'd0, bubble_count}, {16'd0, b0});
    idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      imem_ready = ($urandom_range(0, 4) != 0);
      id_valid = $urandom_range(0, 1); id_uses_rs1 = $urandom_range(0, 1);
      id_uses_rs2 = $urandom_range(0, 1); ex_valid = ($urandom_range(0, 3) != 0);
      ex_is_load = $urandom_range(0, 1); ex_branch_taken = ($urandom_range(0, 7) == 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      #1; check_model($sformatf("rand%0d", i));
      tick();
    end

    // Asynchronous reset dropped mid-flush, between edges.
    idle(); ex_valid = 1'b1; ex_branch_taken = 1'b1;
    tick();
    idle(); check("midflush.state", {30'd0, state}, 32'd2);
    #1; rst_n = 1'b0;
    #1; check("async.ctrl", {27'd0, dut_ctrl()}, 32'd0);
    check("async.state", {30'd0, state}, 32'd0);
    check("async.bubbles", {16'd0, bubble_count}, 32'd0);
    m_reset();
    tick();

    // Saturation: accumulate bubbles with a held load-use stall.
    restart();
    set_load_use(5'd3);
    for (int i = 0; i < 70000 && m_bub != 16'hFFFE; i++) tick();
    check("sat.pre", {16'd0, bubble_count}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) tick();
    check("sat.hold", {16'd0, bubble_count}, 32'h0000FFFF);
    check("sat.ctrl", {27'd0, dut_ctrl()}, 32'b00011);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
